// File: rtl/cred_enroll_pkg.sv
// Shared definitions for the credential enrollment block: FSM state
// encoding and the field widths of a stored credential.
package cred_enroll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    USER,
    PASS,
    SCAN,
    WRITE,
    ERR
  } state_t;

  localparam int USER_W   = 16;
  localparam int PASS_W   = 20;
  localparam int USER_NIB = 4;
  localparam int PASS_NIB = 5;
  localparam int NIB_W    = 4;
  localparam int NIB_CW   = 3;
  localparam int CRED_W   = USER_W + PASS_W;

endpackage

// File: rtl/cred_enroll_if.sv
// Keypad-side controls plus the lookup/status port of the enrollment block.
// The controller (or bench) uses master; cred_enroll uses slave.
interface cred_enroll_if #(parameter int AW = 3);
  import cred_enroll_pkg::*;

  logic              start;
  logic              btn;
  logic [NIB_W-1:0]  swt;
  logic              abort;
  logic [AW-1:0]     lk_addr;
  logic [USER_W-1:0] lk_user;
  logic [PASS_W-1:0] lk_pass;
  logic              lk_valid;
  logic [AW:0]       slot_cnt;
  logic              busy;
  logic              done;
  logic              err_dup;
  logic              err_full;

  modport master (
    output start, btn, swt, abort, lk_addr,
    input  lk_user, lk_pass, lk_valid, slot_cnt, busy, done, err_dup, err_full
  );

  modport slave (
    input  start, btn, swt, abort, lk_addr,
    output lk_user, lk_pass, lk_valid, slot_cnt, busy, done, err_dup, err_full
  );

endinterface

// File: rtl/cred_ram.sv
// Credential storage: one write port, a scan read port that only returns
// the user-ID field, and a full-width lookup read port. Both reads are
// synchronous and return the pre-write contents on an address collision.
module cred_ram
  import cred_enroll_pkg::*;
#(
  parameter int SLOTS = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [CRED_W-1:0] wdata,
  input  logic [AW-1:0]     scan_addr,
  output logic [USER_W-1:0] scan_user,
  input  logic [AW-1:0]     lk_addr,
  output logic [CRED_W-1:0] lk_data
);

  logic [CRED_W-1:0] mem [SLOTS];

  // Write and both registered reads; non-blocking gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    scan_user <= mem[scan_addr][CRED_W-1 -: USER_W];
    lk_data   <= mem[lk_addr];
  end

endmodule

// File: rtl/cred_enroll.sv
// Credential enrollment: collects a 4-nibble user ID and a 5-nibble password
// from a debounced keypad, rejects IDs already in the table, and appends new
// credentials to the RAM. A separate lookup port serves the access controller.
module cred_enroll
  import cred_enroll_pkg::*;
#(
  parameter int SLOTS = 8,
  parameter int AW    = 3
) (
  input logic          clk,
  input logic          rst,
  cred_enroll_if.slave bus
);

  localparam logic [AW:0]       FULL      = (AW+1)'(SLOTS);
  localparam logic [NIB_CW-1:0] USER_LAST = NIB_CW'(USER_NIB - 1);
  localparam logic [NIB_CW-1:0] PASS_LAST = NIB_CW'(PASS_NIB - 1);

  state_t            state;
  logic [AW:0]       slot_cnt;
  logic [USER_W-1:0] user_reg;
  logic [PASS_W-1:0] pass_reg;
  logic [NIB_CW-1:0] nib_cnt;
  logic [AW:0]       scan_idx;
  logic              cmp_valid;
  logic              done_q;
  logic              err_dup_q;
  logic              err_full_q;
  logic              lk_valid_q;
  logic              rd_ok;

  logic              ram_we;
  logic [USER_W-1:0] scan_user;
  logic [CRED_W-1:0] lk_word;

  assign ram_we = (state == WRITE) && (slot_cnt < FULL);

  cred_ram #(
    .SLOTS(SLOTS),
    .AW   (AW)
  ) u_ram (
    .clk      (clk),
    .we       (ram_we),
    .waddr    (slot_cnt[AW-1:0]),
    .wdata    ({user_reg, pass_reg}),
    .scan_addr(scan_idx[AW-1:0]),
    .scan_user(scan_user),
    .lk_addr  (bus.lk_addr),
    .lk_data  (lk_word)
  );

  // Enrollment FSM: nibble capture, duplicate scan, append, status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      user_reg   <= '0;
      pass_reg   <= '0;
      nib_cnt    <= '0;
      scan_idx   <= '0;
      cmp_valid  <= 1'b0;
      done_q     <= 1'b0;
      err_dup_q  <= 1'b0;
      err_full_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_dup_q  <= 1'b0;
      err_full_q <= 1'b0;
      cmp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (slot_cnt < FULL) begin
              state    <= USER;
              nib_cnt  <= '0;
              user_reg <= '0;
              pass_reg <= '0;
            end else begin
              err_full_q <= 1'b1;
            end
          end
        end
        USER: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.btn) begin
            user_reg <= {user_reg[USER_W-NIB_W-1:0], bus.swt};
            if (nib_cnt == USER_LAST) begin
              nib_cnt <= '0;
              state   <= PASS;
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end
        end
        PASS: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.btn) begin
            pass_reg <= {pass_reg[PASS_W-NIB_W-1:0], bus.swt};
            if (nib_cnt == PASS_LAST) begin
              nib_cnt  <= '0;
              scan_idx <= '0;
              state    <= SCAN;
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end
        end
        SCAN: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (cmp_valid && (scan_user == user_reg)) begin
            state <= ERR;
          end else if (scan_idx == slot_cnt) begin
            state <= WRITE;
          end else begin
            scan_idx  <= scan_idx + 1'b1;
            cmp_valid <= 1'b1;
          end
        end
        WRITE: begin
          if (slot_cnt < FULL) begin
            slot_cnt <= slot_cnt + 1'b1;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        ERR: begin
          err_dup_q <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lookup validity uses the pre-write slot count; rd_ok masks stale RAM
  // read data until the first clock after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_valid_q <= 1'b0;
      rd_ok      <= 1'b0;
    end else begin
      lk_valid_q <= ({1'b0, bus.lk_addr} < slot_cnt);
      rd_ok      <= 1'b1;
    end
  end

  assign bus.lk_user  = rd_ok ? lk_word[CRED_W-1 -: USER_W] : '0;
  assign bus.lk_pass  = rd_ok ? lk_word[PASS_W-1:0] : '0;
  assign bus.lk_valid = lk_valid_q;
  assign bus.slot_cnt = slot_cnt;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.err_dup  = err_dup_q;
  assign bus.err_full = err_full_q;

endmodule

// File: tb/tb_cred_enroll.sv
// Self-checking bench for cred_enroll. Stimulus tasks predict each status
// pulse (kind and cycle) from a plain table model and queue it; a monitor
// on the falling edge pops and compares every pulse the DUT produces.
module tb_cred_enroll;

  localparam int SLOTS = 8;
  localparam int AW    = 3;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_DUP  = 3'b010;
  localparam logic [2:0] K_FULL = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] m_user[SLOTS];
  logic [19:0] m_pass[SLOTS];
  int          m_cnt = 0;

  cred_enroll_if #(.AW(AW)) bus();

  cred_enroll #(
    .SLOTS(SLOTS),
    .AW   (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so a stuck run still terminates.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every status pulse must match the oldest prediction.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [2:0] got;
    if (!rst && (bus.done || bus.err_dup || bus.err_full)) begin
      got = {bus.err_full, bus.err_dup, bus.done};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_pulse got=%b at cycle %0d, want none", got, cyc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e.kind || cyc != e.cyc) begin
          n_fail++;
          $display("[TB] FAIL pulse got=%b@%0d want=%b@%0d", got, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h want=%h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic expectPulse(input logic [2:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Full enrollment with random idle gaps between nibbles; predicts outcome.
  task automatic applyStimulus(input logic [15:0] user, input logic [19:0] pass,
                               output int t_last, output int old_cnt);
    int hit;
    hit     = -1;
    old_cnt = m_cnt;
    t_last  = cyc;
    bus.start = 1'b1;
    if (old_cnt == SLOTS) expectPulse(K_FULL, cyc + 1);
    tick();
    bus.start = 1'b0;
    if (old_cnt == SLOTS) begin
      checkOutput("busy_after_full_start", 32'(bus.busy), 32'd0);
      return;
    end
    checkOutput("busy_in_enroll", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        bus.swt = 4'($urandom);
        tick();
      end
      if (i < 4) bus.swt = user[15-4*i -: 4];
      else       bus.swt = pass[19-4*(i-4) -: 4];
      bus.btn = 1'b1;
      if (i == 8) t_last = cyc;
      tick();
      bus.btn = 1'b0;
    end
    for (int k = 0; k < m_cnt; k++)
      if (hit < 0 && m_user[k] == user) hit = k;
    if (hit >= 0) begin
      expectPulse(K_DUP, t_last + hit + 4);
    end else begin
      expectPulse(K_DONE, t_last + m_cnt + 3);
      m_user[m_cnt] = user;
      m_pass[m_cnt] = pass;
      m_cnt++;
    end
  endtask

  // Start, enter some nibbles, then abort (optionally with btn the same cycle).
  task automatic abortEnroll(input int n_nib, input bit with_btn);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n_nib; i++) begin
      bus.swt = 4'($urandom);
      bus.btn = 1'b1;
      tick();
      bus.btn = 1'b0;
    end
    bus.abort = 1'b1;
    bus.btn   = with_btn;
    bus.swt   = 4'hF;
    tick();
    bus.abort = 1'b0;
    bus.btn   = 1'b0;
    checkOutput("busy_after_abort", 32'(bus.busy), 32'd0);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) tick();
    checkOutput("pending_pulses", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  task automatic checkLookup(input int addr);
    bus.lk_addr = AW'(addr);
    tick();
    checkOutput("lk_valid", 32'(bus.lk_valid), 32'(addr < m_cnt));
    if (addr < m_cnt) begin
      checkOutput("lk_user", 32'(bus.lk_user), 32'(m_user[addr]));
      checkOutput("lk_pass", 32'(bus.lk_pass), 32'(m_pass[addr]));
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    m_cnt = 0;
    exp_q.delete();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int t, oc;
    logic [15:0] pool[10];
    bus.start = 1'b0; bus.btn = 1'b0; bus.abort = 1'b0;
    bus.swt = 4'h0; bus.lk_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy",     32'(bus.busy),     32'd0);
    checkOutput("rst_slot_cnt", 32'(bus.slot_cnt), 32'd0);
    checkOutput("rst_done",     32'(bus.done),     32'd0);
    checkOutput("rst_lk_valid", 32'(bus.lk_valid), 32'd0);
    checkOutput("rst_lk_user",  32'(bus.lk_user),  32'd0);
    checkOutput("rst_lk_pass",  32'(bus.lk_pass),  32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] first enrollment into empty table");
    applyStimulus(16'hABCD, 20'h12345, t, oc);
    waitDrain();
    checkOutput("slot_cnt_one", 32'(bus.slot_cnt), 32'd1);
    checkLookup(0);

    $display("[TB] duplicate user ID");
    applyStimulus(16'hABCD, 20'h99999, t, oc);
    waitDrain();
    checkOutput("slot_cnt_after_dup", 32'(bus.slot_cnt), 32'd1);
    checkLookup(0);
    checkLookup(1);

    $display("[TB] aborts followed by a clean enrollment");
    abortEnroll(2, 1'b0);
    abortEnroll(1, 1'b1);
    waitDrain();
    applyStimulus(16'h1111, 20'h22222, t, oc);
    waitDrain();
    checkLookup(1);
    applyStimulus(16'h5A5A, 20'($urandom), t, oc);
    waitDrain();
    checkOutput("slot_cnt_three", 32'(bus.slot_cnt), 32'd3);

    $display("[TB] reset in the middle of the password");
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.swt = 4'($urandom); bus.btn = 1'b1; tick(); bus.btn = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy",     32'(bus.busy),     32'd0);
    checkOutput("midrst_slot_cnt", 32'(bus.slot_cnt), 32'd0);
    checkOutput("midrst_done",     32'(bus.done),     32'd0);
    checkOutput("midrst_err_dup",  32'(bus.err_dup),  32'd0);
    checkOutput("midrst_err_full", 32'(bus.err_full), 32'd0);
    checkOutput("midrst_lk_valid", 32'(bus.lk_valid), 32'd0);
    checkOutput("midrst_lk_user",  32'(bus.lk_user),  32'd0);
    checkOutput("midrst_lk_pass",  32'(bus.lk_pass),  32'd0);
    m_cnt = 0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    checkLookup(0);
    repeat (4) tick();
    checkOutput("no_write_after_rst", 32'(bus.slot_cnt), 32'd0);

    $display("[TB] fill the table with IDs 0001..0008");
    for (int n = 1; n <= SLOTS; n++) begin
      bus.lk_addr = AW'(m_cnt);
      applyStimulus(16'(n), 20'($urandom), t, oc);
      if (n == 5) begin
        while (cyc < t + oc + 3) tick();
        checkOutput("collide_lk_valid_old", 32'(bus.lk_valid), 32'(oc < oc));
        tick();
        checkOutput("collide_lk_valid_new", 32'(bus.lk_valid), 32'(oc < m_cnt));
        checkOutput("collide_lk_user",      32'(bus.lk_user),  32'(m_user[oc]));
      end
      waitDrain();
    end
    applyStimulus(16'h0FFF, 20'h00001, t, oc);
    waitDrain();
    checkOutput("busy_stays_idle", 32'(bus.busy),     32'd0);
    checkOutput("slot_cnt_full",   32'(bus.slot_cnt), 32'd8);
    for (int a = 0; a < SLOTS; a++) checkLookup(a);

    $display("[TB] randomized enrollments with duplicates and aborts");
    doReset();
    for (int j = 0; j < 10; j++) pool[j] = 16'($urandom);
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        abortEnroll($urandom_range(0, 8), 1'($urandom));
      end else begin
        applyStimulus(pool[$urandom_range(0, 9)], 20'($urandom), t, oc);
      end
      waitDrain();
      checkOutput("rand_slot_cnt", 32'(bus.slot_cnt), 32'(m_cnt));
      checkLookup($urandom_range(0, SLOTS - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cred_enroll.md
CRED_ENROLL -- requirements
Module: cred_enroll

Interface
REQ-001 Parameter SLOTS, default 8, number of credential slots.
REQ-002 Parameter AW, default 3, slot address width; SLOTS SHALL equal 2**AW.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins an enrollment.
REQ-006 btn  input  1  one-cycle debounced pulse; captures swt as the next nibble.
REQ-007 swt  input  4  nibble to capture.
REQ-008 abort  input  1  one-cycle pulse; discards the enrollment in progress.
REQ-009 lk_addr  input  AW  lookup slot address for the access controller.
REQ-010 lk_user  output  16  user ID stored at lk_addr.
REQ-011 lk_pass  output  20  password stored at lk_addr.
REQ-012 lk_valid  output  1  high when lk_addr < slot_cnt.
REQ-013 slot_cnt  output  AW+1  number of enrolled slots.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; credential written.
REQ-016 err_dup  output  1  one-cycle pulse; user ID already enrolled, nothing written.
REQ-017 err_full  output  1  one-cycle pulse; start received with the table full.

Function
REQ-018 FSM states: IDLE, USER, PASS, SCAN, WRITE, ERR.
REQ-019 IDLE to USER on start when slot_cnt < SLOTS; clear the nibble counter.
REQ-020 start in IDLE with slot_cnt == SLOTS: pulse err_full on the next cycle and stay in IDLE.
REQ-021 start outside IDLE: ignored.
REQ-022 USER: each btn shifts swt in MSB-first into a 16-bit user register; after the 4th nibble, go to PASS.
REQ-023 PASS: each btn shifts swt in MSB-first into a 20-bit password register; after the 5th nibble, go to SCAN.
REQ-024 btn in IDLE, SCAN, WRITE or ERR: ignored.
REQ-025 abort in USER, PASS or SCAN: next state IDLE; nothing written; no pulse.
REQ-026 abort and btn in the same cycle: abort wins.
REQ-027 SCAN reads slots 0..slot_cnt-1 in order through the internal read port, with 1-cycle read latency.
REQ-028 SCAN compares each returned user ID against the user register.
REQ-029 Any match in SCAN: go to ERR immediately (early exit).
REQ-030 SCAN completes in slot_cnt+1 cycles; with slot_cnt == 0 it SHALL last exactly 1 cycle.
REQ-031 WRITE, one cycle: store {user, password} at address slot_cnt; increment slot_cnt; assert done; return to IDLE.
REQ-032 ERR, one cycle: assert err_dup; return to IDLE.
REQ-033 Latency: last PASS btn at cycle T gives done high at cycle T+slot_cnt+3.
REQ-034 Lookup port: synchronous read; lk_user, lk_pass and lk_valid SHALL update 1 cycle after lk_addr.
REQ-035 A lookup in the same cycle as a WRITE to the same slot SHALL return the old data plus lk_valid as it was before the write.
REQ-036 slot_cnt saturates at SLOTS; it never wraps.

Reset
REQ-037 rst SHALL force: state IDLE, slot_cnt 0, shift registers 0, nibble counter 0, done/err_dup/err_full/lk_valid 0, busy 0, lk_user/lk_pass 0.
REQ-038 RAM contents are not cleared by rst; they become invalid because slot_cnt returns to 0.
REQ-039 rst mid-enrollment: the partial credential is discarded and no write occurs.

Structure
REQ-040 Shared package holds: state encoding, USER_W=16, PASS_W=20, USER_NIB=4, PASS_NIB=5.
REQ-041 Sub-module cred_ram: SLOTS x 36 bits, one write port, two synchronous read ports (scan and lookup), no reset.

Verification
REQ-042 Empty table: start, nibbles A,B,C,D, then 1,2,3,4,5 -> done at T+3; slot_cnt=1; lk_addr=0 gives lk_user=16'hABCD, lk_pass=20'h12345, lk_valid=1.
REQ-043 Duplicate: enroll 16'hABCD again with password 99999 -> err_dup one pulse; slot_cnt stays 1; slot 0 unchanged.
REQ-044 Full: enroll 8 distinct IDs 0001..0008, then start -> err_full pulse; busy stays 0; slot_cnt=8.
REQ-045 Abort after 2 user nibbles, then a fresh enrollment of 16'h1111/20'h22222 -> stored exactly; no stale nibbles.
REQ-046 Assert rst during PASS with slot_cnt=3 -> all outputs 0 immediately; slot_cnt=0; lk_valid=0 for lk_addr=0.
REQ-047 abort and btn in the same cycle during USER -> IDLE; no capture.
